// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter with round-robin fairness and one outstanding transaction.
// Address-phase signals and read responses pass through combinationally; state, pointer, owner and err are registered.
module obi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_be_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [NUM_MASTERS*DATA_W-1:0]     m_rdata_o,
  output logic                              s_req_o,
  input  logic                              s_gnt_i,
  output logic [ADDR_W-1:0]                 s_addr_o,
  output logic                              s_we_o,
  output logic [DATA_W/8-1:0]               s_be_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  input  logic                              s_rvalid_i,
  input  logic [DATA_W-1:0]                 s_rdata_i,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel;
  logic             any_req;
  logic             found;
  logic [IDX_W:0]   cand;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_MASTERS - 1)) ? '0 : x + IDX_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping N-1 -> 0
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (!found && m_req_i[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign any_req = |m_req_i;
  assign sel     = (state == IDLE) ? winner : owner;

  // Address-phase mux, grants and response routing
  always_comb begin
    s_req_o    = 1'b0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (sel == IDX_W'(k)) begin
        s_addr_o  = m_addr_i[k*ADDR_W +: ADDR_W];
        s_we_o    = m_we_i[k];
        s_be_o    = m_be_i[k*BE_W +: BE_W];
        s_wdata_o = m_wdata_i[k*DATA_W +: DATA_W];
      end
      if (state == RESP && owner == IDX_W'(k)) begin
        m_rdata_o[k*DATA_W +: DATA_W] = s_rdata_i;
      end
    end
    case (state)
      IDLE: begin
        s_req_o = any_req;
        if (any_req) m_gnt_o[winner] = s_gnt_i;
      end
      ADDR: begin
        s_req_o        = m_req_i[owner];
        m_gnt_o[owner] = s_gnt_i & m_req_i[owner];
      end
      RESP: begin
        m_rvalid_o[owner] = s_rvalid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      err_o  <= 1'b0;
    end else begin
      err_o <= s_rvalid_i && (state != RESP);
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            if (s_gnt_i) begin
              rr_ptr <= inc_wrap(winner);
              if (!m_we_i[winner]) state <= RESP;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          // A master withdrawing its locked request releases the lock ungranted
          if (!m_req_i[owner]) begin
            state <= IDLE;
          end else if (s_gnt_i) begin
            rr_ptr <= inc_wrap(owner);
            state  <= m_we_i[owner] ? IDLE : RESP;
          end
        end
        RESP: begin
          if (s_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner_o = owner;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: vector table, directed corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_obi_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      m_req;
  logic [N-1:0]      m_gnt;
  logic [N*AW-1:0]   m_addr;
  logic [N-1:0]      m_we;
  logic [N*BW-1:0]   m_be;
  logic [N*DW-1:0]   m_wdata;
  logic [N-1:0]      m_rvalid;
  logic [N*DW-1:0]   m_rdata;
  logic              s_req;
  logic              s_gnt;
  logic [AW-1:0]     s_addr;
  logic              s_we;
  logic [BW-1:0]     s_be;
  logic [DW-1:0]     s_wdata;
  logic              s_rvalid;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        owner;
  logic              busy;
  logic              err;

  int checks = 0;
  int failures = 0;

  obi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .owner_o(owner), .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic         gnt;
    logic [N-1:0] exp_gnt;
    logic         exp_sreq;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model: pending lock, outstanding read owner, pointer as plain integers
  int md_lock, md_rd, md_ptr, md_own;
  bit md_err;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  vec_t tbl[8];

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state
    settle();
    chk("rst_busy",   128'(busy),     128'(0));
    chk("rst_owner",  128'(owner),    128'(0));
    chk("rst_err",    128'(err),      128'(0));
    chk("rst_gnt",    128'(m_gnt),    128'(0));
    chk("rst_sreq",   128'(s_req),    128'(0));
    chk("rst_rvalid", 128'(m_rvalid), 128'(0));
    chk("rst_rdata",  128'(m_rdata),  128'(0));

    // Write round-robin vectors
    tbl[0] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1};
    tbl[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1};
    tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[5] = '{4'b0101, 4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[6] = '{4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[7] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0};
    tick();
    for (int i = 0; i < 8; i++) begin
      m_req = tbl[i].req; m_we = tbl[i].we; s_gnt = tbl[i].gnt;
      settle();
      chk($sformatf("tbl%0d_gnt", i),  128'(m_gnt), 128'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_sreq", i), 128'(s_req), 128'(tbl[i].exp_sreq));
      chk($sformatf("tbl%0d_busy", i), 128'(busy),  128'(0));
      tick();
    end

    // Read by master 2 with three-cycle response latency
    do_reset();
    m_req = 4'b0100; m_we = 4'b0000; s_gnt = 1'b1;
    settle();
    chk("rd_gnt", 128'(m_gnt), 128'(4'b0100));
    tick();
    m_req = '0; s_gnt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; end
      settle();
      chk($sformatf("rd_busy_t%0d", i), 128'(busy), 128'(1));
      chk($sformatf("rd_sreq_t%0d", i), 128'(s_req), 128'(0));
      if (i == 3) begin
        chk("rd_rvalid", 128'(m_rvalid), 128'(4'b0100));
        chk("rd_rdata",  128'(m_rdata),  {32'h0, 32'hDEADBEEF, 64'h0});
      end else begin
        chk($sformatf("rd_rvalid_t%0d", i), 128'(m_rvalid), 128'(0));
      end
      tick();
    end
    s_rvalid = 1'b0; s_rdata = '0;
    settle();
    chk("rd_busy_end", 128'(busy), 128'(0));
    chk("rd_err_end",  128'(err),  128'(0));

    // Stalled address phase stays locked to master 1
    do_reset();
    m_addr = {32'h0, 32'h0, 32'h1111_0004, 32'h0000_0A00};
    m_we = 4'b1111; m_req = 4'b0010; s_gnt = 1'b0;
    settle();
    chk("lock_sreq0", 128'(s_req),  128'(1));
    chk("lock_addr0", 128'(s_addr), 128'(32'h1111_0004));
    tick();
    m_req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("lock_owner%0d", i), 128'(owner),  128'(1));
      chk($sformatf("lock_addr%0d", i),  128'(s_addr), 128'(32'h1111_0004));
      chk($sformatf("lock_gnt%0d", i),   128'(m_gnt),  128'(0));
      tick();
    end
    s_gnt = 1'b1;
    settle();
    chk("lock_gnt_m1", 128'(m_gnt), 128'(4'b0010));
    tick();
    m_req = 4'b0001;
    settle();
    chk("lock_gnt_m0",  128'(m_gnt),  128'(4'b0001));
    chk("lock_addr_m0", 128'(s_addr), 128'(32'h0000_0A00));
    tick();

    // Spurious response in IDLE
    do_reset();
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
    settle();
    chk("spur_rvalid", 128'(m_rvalid), 128'(0));
    chk("spur_rdata",  128'(m_rdata),  128'(0));
    tick();
    s_rvalid = 1'b0;
    settle();
    chk("spur_err", 128'(err), 128'(1));
    tick();
    settle();
    chk("spur_err_clr", 128'(err), 128'(0));

    // Reset while a read is outstanding
    do_reset();
    m_req = 4'b0001; m_we = 4'b0000; s_gnt = 1'b1;
    settle();
    chk("rr_gnt0", 128'(m_gnt), 128'(4'b0001));
    tick();
    m_req = '0; s_gnt = 1'b0;
    settle();
    chk("rr_busy_resp", 128'(busy), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rr_busy_after", 128'(busy),  128'(0));
    chk("rr_owner_after", 128'(owner), 128'(0));
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    settle();
    chk("rr_late_rvalid", 128'(m_rvalid), 128'(0));
    chk("rr_late_rdata",  128'(m_rdata),  128'(0));
    tick();
    s_rvalid = 1'b0; m_req = 4'b1111; m_we = 4'b1111; s_gnt = 1'b1;
    settle();
    chk("rr_late_err", 128'(err),   128'(1));
    chk("rr_ptr_zero", 128'(m_gnt), 128'(4'b0001));
    tick();
    clear_inputs();

    // Back-to-back reads from master 3, slave answers one cycle after grant
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m_req = 4'b1000; m_we = 4'b0000; s_gnt = 1'b1;
      s_rvalid = 1'(i % 2); s_rdata = 32'hC0DE_0000 + 32'(i);
      settle();
      if (i % 2 == 0) begin
        chk($sformatf("b2b_gnt%0d", i),  128'(m_gnt), 128'(4'b1000));
        chk($sformatf("b2b_busy%0d", i), 128'(busy),  128'(0));
      end else begin
        chk($sformatf("b2b_gnt%0d", i),    128'(m_gnt),    128'(0));
        chk($sformatf("b2b_busy%0d", i),   128'(busy),     128'(1));
        chk($sformatf("b2b_rvalid%0d", i), 128'(m_rvalid), 128'(4'b1000));
        chk($sformatf("b2b_rdata%0d", i),  128'(m_rdata),  {32'hC0DE_0000 + 32'(i), 96'h0});
      end
      tick();
    end

    // Randomized traffic against the reference model
    do_reset();
    md_lock = -1; md_rd = -1; md_ptr = 0; md_own = 0; md_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [N-1:0]    e_gnt;
      logic [N-1:0]    e_rvalid;
      logic [N*DW-1:0] e_rdata;
      logic            e_sreq;
      int              w;
      int              src;
      bit              inject;

      for (int k = 0; k < N; k++) begin
        m_addr[k*AW +: AW]  = $urandom();
        m_wdata[k*DW +: DW] = $urandom();
      end
      m_be    = 16'($urandom());
      m_we    = 4'($urandom());
      m_req   = 4'($urandom());
      s_gnt   = 1'($urandom_range(0, 1));
      s_rdata = $urandom();
      s_rvalid = 1'b0;
      inject = (md_rd < 0) && (md_lock < 0) && ($urandom_range(0, 19) == 0);
      if (inject) begin
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
      end else if (md_rd >= 0) begin
        s_rvalid = ($urandom_range(0, 2) == 0);
      end

      e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_sreq = 1'b0; src = -1;
      w = rr_pick(m_req, md_ptr);
      if (md_rd >= 0) begin
        e_rvalid[md_rd] = s_rvalid;
        e_rdata[md_rd*DW +: DW] = s_rdata;
      end else if (md_lock >= 0) begin
        e_sreq = m_req[md_lock];
        e_gnt[md_lock] = s_gnt & m_req[md_lock];
        src = md_lock;
      end else if (w >= 0) begin
        e_sreq = 1'b1;
        e_gnt[w] = s_gnt;
        src = w;
      end

      settle();
      chk("rnd_gnt",    128'(m_gnt),    128'(e_gnt));
      chk("rnd_sreq",   128'(s_req),    128'(e_sreq));
      chk("rnd_rvalid", 128'(m_rvalid), 128'(e_rvalid));
      chk("rnd_rdata",  128'(m_rdata),  128'(e_rdata));
      chk("rnd_busy",   128'(busy),     128'(md_lock >= 0 || md_rd >= 0));
      chk("rnd_owner",  128'(owner),    128'(md_own));
      chk("rnd_err",    128'(err),      128'(md_err));
      if (src >= 0) begin
        chk("rnd_addr",  128'(s_addr),  128'(m_addr[src*AW +: AW]));
        chk("rnd_we",    128'(s_we),    128'(m_we[src]));
        chk("rnd_be",    128'(s_be),    128'(m_be[src*BW +: BW]));
        chk("rnd_wdata", 128'(s_wdata), 128'(m_wdata[src*DW +: DW]));
      end

      md_err = s_rvalid && (md_rd < 0);
      if (md_rd >= 0) begin
        if (s_rvalid) md_rd = -1;
      end else if (md_lock >= 0) begin
        if (!m_req[md_lock]) begin
          md_lock = -1;
        end else if (s_gnt) begin
          md_ptr = (md_lock + 1) % N;
          if (!m_we[md_lock]) md_rd = md_lock;
          md_lock = -1;
        end
      end else if (w >= 0) begin
        md_own = w;
        if (s_gnt) begin
          md_ptr = (w + 1) % N;
          if (!m_we[w]) md_rd = w;
        end else begin
          md_lock = w;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
